mem_arbiter: RTL

Two-port to one-port memory arbiter that lets the pipeline CPU's instruction-fetch port (IM_*) and data port (DM_*) share a single synchronous single-port memory (MEM_*). It sits between the CPU and the unified memory macro. It serializes accesses with a small state machine, gives data accesses priority with starvation protection for fetch, and returns per-port valid pulses plus a stall signal for the pipeline.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one synchronous single-port memory between an instruction
//            fetch port and a data port with alternating-priority arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_en,
  input  logic [ADDR_W-1:0] IM_address,
  output logic [DATA_W-1:0] IM_out,
  output logic              IM_valid,
  input  logic              DM_en,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              DM_valid,
  output logic              stall,
  output logic              MEM_en,
  output logic              MEM_write,
  output logic [ADDR_W-1:0] MEM_address,
  output logic [DATA_W-1:0] MEM_in,
  input  logic [DATA_W-1:0] MEM_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [2:0] c_LAT     = 3'(MEM_LAT);
  localparam logic       c_PORT_IM = 1'b0;
  localparam logic       c_PORT_DM = 1'b1;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last, w_last_nxt;
  logic              r_im_valid, r_dm_valid;
  logic [DATA_W-1:0] r_im_out, r_dm_out;
  logic              w_im_req, w_dm_req, w_gnt_dm, w_can_issue, w_capture;

  // A port is blind to its own request during its valid cycle.
  assign w_im_req    = IM_en & ~r_im_valid;
  assign w_dm_req    = DM_en & ~r_dm_valid;
  assign w_gnt_dm    = w_dm_req & (~w_im_req | (r_last == c_PORT_IM));
  assign w_can_issue = ~rst & (w_im_req | w_dm_req) &
                       ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_capture   = (r_state == S_RD_WAIT) && (r_cnt == c_LAT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    MEM_en      = 1'b0;
    MEM_write   = 1'b0;
    MEM_address = '0;
    MEM_in      = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_can_issue) begin
          MEM_en      = 1'b1;
          w_owner_nxt = w_gnt_dm;
          w_last_nxt  = w_gnt_dm;
          w_cnt_nxt   = 3'd1;
          if (w_gnt_dm) begin
            MEM_address = DM_address;
            MEM_in      = DM_in;
            MEM_write   = DM_write;
            w_state_nxt = DM_write ? S_DONE : S_RD_WAIT;
          end else begin
            MEM_address = IM_address;
            w_state_nxt = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (w_capture) w_state_nxt = S_DONE;
        else           w_cnt_nxt   = r_cnt + 3'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_owner    <= c_PORT_IM;
      r_last     <= c_PORT_IM;
      r_im_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_im_out   <= '0;
      r_dm_out   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_im_valid <= (w_state_nxt == S_DONE) && (w_owner_nxt == c_PORT_IM);
      r_dm_valid <= (w_state_nxt == S_DONE) && (w_owner_nxt == c_PORT_DM);
      if (w_capture && (r_owner == c_PORT_IM)) r_im_out <= MEM_out;
      if (w_capture && (r_owner == c_PORT_DM)) r_dm_out <= MEM_out;
    end
  end

  assign IM_out   = r_im_out;
  assign DM_out   = r_dm_out;
  assign IM_valid = r_im_valid;
  assign DM_valid = r_dm_valid;
  assign stall    = (IM_en & ~r_im_valid) | (DM_en & ~r_dm_valid);

endmodule
`default_nettype wire
